dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised successor data memory for the MEM stage of the 5-stage RISC-V pipeline.
- Word-organised RAM with byte-lane writes (sb/sh/sw at any legal offset) and full load extraction (lb/lh/lw/lbu/lhu at any legal offset).
- Valid/ready request port and registered response with configurable wait states, so the hazard unit can stall on memory.
- Misaligned, out-of-range and illegal-funct3 accesses are flagged as errors; there is no modulo wrap.

Parameters:
- DATA_WIDTH, 32, word width; fixed at 32 for RV32.
- ADDR_WIDTH, 32, byte address width.
- MEM_SIZE, 64, depth in words; any value ≥ 2.
- WAIT_CYCLES, 0, extra response latency in cycles, 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; qualified by rsp_valid.

Behaviour:
- Clock/reset: single clock domain (clk). Reset is synchronous, active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, state=IDLE. RAM contents are not reset.
- Accept: the request is accepted on a rising edge with req_valid && req_ready. One request per cycle at most.
- Word index: req_addr[ADDR_WIDTH-1:2].
- Error if any of the following (evaluated at accept):
  - index ≥ MEM_SIZE;
  - funct3 ∉ {000, 001, 010, 100, 101} for loads;
  - funct3 ∉ {000, 001, 010} for stores;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠00.
- Error response: the RAM is not written, rsp_err=1, rsp_rdata=0.
- Store: committed to the RAM on the accept edge.
  - sb writes byte lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - sw writes all four lanes.
  - Other lanes are unchanged.
  - Response: rsp_rdata=0, rsp_err=0.
- Load: the word is read on the accept edge and registered.
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - Sign-extended for lb/lh, zero-extended for lbu/lhu, unchanged for lw.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; counter loaded with WAIT_CYCLES on accept and decremented each cycle.
  - WAIT→IDLE when the counter reaches 1.
  - IDLE→WAIT on accept only when WAIT_CYCLES>0.
- Timing: accept at edge k gives rsp_valid=1 for exactly the cycle after edge k+WAIT_CYCLES. rsp_valid is otherwise 0.
- Response hold: rsp_rdata and rsp_err hold their last values when rsp_valid=0.
- Back-to-back, WAIT_CYCLES=0: req_ready stays 1 and throughput is 1 access per cycle.
- Back-to-back, WAIT_CYCLES=N: req_ready drops for N cycles and returns to 1 in the response cycle. A new accept in that cycle is legal.
- No response backpressure: the consumer always takes rsp.
- Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
- Reset mid-operation:
  - Any pending response is dropped; no rsp_valid is issued for it.
  - A store already accepted remains committed.
- Inputs other than req_valid are don't-care while req_valid=0.

Optional Feature:
- Macro: DMEM_PERF_EN.
- Defined: adds output ports perf_loads, perf_stores and perf_errs, each 16 bits.
  - Each counter increments on the accept edge of a non-error load, a non-error store, or any error respectively.
  - Counters saturate at 16'hFFFF.
  - Counters clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYCLES=0: sw addr 0x10 data 0x8081_7F02, then lb 0x10/0x11/0x12/0x13 back-to-back → rsp_rdata 0x0000_0002, 0x0000_007F, 0xFFFF_FF81, 0xFFFF_FF80 on consecutive cycles, req_ready constantly 1.
- sh 0x22 data 0x0000_BEEF over word 0x20 = 0x1111_1111, then lw 0x20 → 0xBEEF_1111; then lh 0x22 → 0xFFFF_BEEF and lhu 0x22 → 0x0000_BEEF.
- Misaligned and out-of-range, all expecting rsp_err=1 and rsp_rdata=0:
  - sw 0x21 → RAM unchanged (a following lw 0x20 returns the prior value);
  - lh 0x23;
  - lw 0x100 with MEM_SIZE=64.
- WAIT_CYCLES=3: lw accepted at edge k → req_ready=0 for 3 cycles, rsp_valid high only in the cycle after edge k+3; a second request held on req_valid is accepted in that same cycle.
- WAIT_CYCLES=3: reset asserted one cycle after a load is accepted → no rsp_valid for the dropped load, req_ready=1 the cycle after reset, outputs at reset values; sb issued before the reset remains visible to a later lbu.
- With DMEM_PERF_EN: 3 loads, 2 stores, 1 misaligned store → perf_loads=3, perf_stores=2, perf_errs=1; reset clears all three to 0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage data memory with byte-lane stores, load extraction and wait states
//
// Purpose:
//   Word-organised RAM serving RV32 loads/stores from the MEM stage. A request is
//   accepted on req_valid && req_ready; stores commit on the accept edge, loads
//   read and extend on the accept edge. The response is registered and appears
//   WAIT_CYCLES cycles later as a one-cycle rsp_valid pulse. Misaligned,
//   out-of-range and illegal-funct3 accesses return rsp_err=1 with rsp_rdata=0
//   and never touch the RAM.
//
// Optional build macro:
//   DMEM_PERF_EN - adds saturating 16-bit counters perf_loads/perf_stores/perf_errs.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   req_valid    in   request present
//   req_ready    out  request can be accepted (1 in IDLE)
//   req_we       in   1 = store, 0 = load
//   req_funct3   in   RV32 load/store funct3
//   req_addr     in   byte address
//   req_wdata    in   right-aligned store data
//   rsp_valid    out  one-cycle response pulse
//   rsp_rdata    out  extended load data (0 for stores/errors), held between pulses
//   rsp_err      out  access faulted, held between pulses
//   perf_loads   out  (DMEM_PERF_EN) accepted non-error loads
//   perf_stores  out  (DMEM_PERF_EN) accepted non-error stores
//   perf_errs    out  (DMEM_PERF_EN) accepted faulting accesses

module dmem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_SIZE    = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
`ifdef DMEM_PERF_EN
  ,
  output logic [15:0]           perf_loads,
  output logic [15:0]           perf_stores,
  output logic [15:0]           perf_errs
`endif
);

  localparam int         IDX_W     = ADDR_WIDTH - 2;
  localparam int         RAM_AW    = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] pend_rdata_q, pend_rdata_d;
  logic                  pend_err_q, pend_err_d;

  logic [IDX_W-1:0]      word_idx;
  logic [RAM_AW-1:0]     ram_idx;
  logic [1:0]            byte_off;
  logic                  accept;
  logic                  range_err;
  logic                  f3_err;
  logic                  align_err;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  mem_we;

  assign word_idx  = req_addr[ADDR_WIDTH-1:2];
  assign ram_idx   = word_idx[RAM_AW-1:0];
  assign byte_off  = req_addr[1:0];
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;

  // Compare at a width wide enough for both operands so no address wraps into range.
  assign range_err = (64'(word_idx) >= 64'(MEM_SIZE));

  always_comb begin
    f3_err    = 1'b0;
    align_err = 1'b0;
    if (req_we) begin
      case (req_funct3)
        F3_B, F3_H, F3_W: f3_err = 1'b0;
        default:          f3_err = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_err = 1'b0;
        default:                        f3_err = 1'b1;
      endcase
    end
    case (req_funct3)
      F3_H, F3_HU: align_err = byte_off[0];
      F3_W:        align_err = |byte_off;
      default:     align_err = 1'b0;
    endcase
  end

  assign acc_err = range_err | f3_err | align_err;

  assign rd_word = mem[ram_idx];

  always_comb begin
    rd_byte = 8'h00;
    case (byte_off)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = 8'h00;
    endcase
    rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    ld_data = '0;
    case (req_funct3)
      F3_B:    ld_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    ld_data = {{16{rd_half[15]}}, rd_half};
      F3_W:    ld_data = rd_word;
      F3_BU:   ld_data = {24'h0, rd_byte};
      F3_HU:   ld_data = {16'h0, rd_half};
      default: ld_data = '0;
    endcase
  end

  assign acc_rdata = (req_we || acc_err) ? '0 : ld_data;

  // Stores are a read-modify-write of the addressed word: replicate the data
  // across lanes and let the mask pick which lanes change.
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    case (req_funct3)
      F3_B: begin
        wr_data = {4{req_wdata[7:0]}};
        wr_mask = 32'h0000_00FF << {byte_off, 3'b000};
      end
      F3_H: begin
        wr_data = {2{req_wdata[15:0]}};
        wr_mask = byte_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      end
      F3_W: begin
        wr_data = req_wdata;
        wr_mask = 32'hFFFF_FFFF;
      end
      default: begin
        wr_data = '0;
        wr_mask = '0;
      end
    endcase
  end

  assign wr_word = (rd_word & ~wr_mask) | (wr_data & wr_mask);
  assign mem_we  = accept && req_we && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ram_idx] <= wr_word;
    end
  end

  // Response path. With no wait states the response registers load directly on
  // the accept edge; otherwise the result parks in pend_* until the counter
  // expires, and the final WAIT edge both publishes it and reopens req_ready.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = acc_rdata;
            rsp_err_d   = acc_err;
          end else begin
            state_d      = S_WAIT;
            cnt_d        = WAIT_INIT;
            pend_rdata_d = acc_rdata;
            pend_err_d   = acc_err;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pend_rdata_q;
          rsp_err_d   = pend_err_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_PERF_EN
  logic [15:0] perf_loads_q,  perf_loads_d;
  logic [15:0] perf_stores_q, perf_stores_d;
  logic [15:0] perf_errs_q,   perf_errs_d;

  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    perf_errs_d   = perf_errs_q;
    if (accept) begin
      if (acc_err) begin
        if (perf_errs_q != 16'hFFFF) perf_errs_d = perf_errs_q + 16'd1;
      end else if (req_we) begin
        if (perf_stores_q != 16'hFFFF) perf_stores_d = perf_stores_q + 16'd1;
      end else begin
        if (perf_loads_q != 16'hFFFF) perf_loads_d = perf_loads_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_loads_q  <= 16'd0;
      perf_stores_q <= 16'd0;
      perf_errs_q   <= 16'd0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
      perf_errs_q   <= perf_errs_d;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_errs   = perf_errs_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with zero and three wait states
module tb_dmem_ctrl;

  localparam int MS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  v, we, rdy, rv, re;
  logic [2:0]  f3 [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
`ifdef DMEM_PERF_EN
  logic [15:0] pl, ps, pe, pl3, ps3, pe3;
`endif

  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(MS), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst), .req_valid(v[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_funct3(f3[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0])
`ifdef DMEM_PERF_EN
    , .perf_loads(pl), .perf_stores(ps), .perf_errs(pe)
`endif
  );

  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(MS), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst), .req_valid(v[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_funct3(f3[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1])
`ifdef DMEM_PERF_EN
    , .perf_loads(pl3), .perf_stores(ps3), .perf_errs(pe3)
`endif
  );

  // ---------------- behavioural model ----------------
  int          wc [2] = '{0, 3};
  int          cyc = 0;
  logic [7:0]  mb [2][MS*4];
  int          busy [2];
  bit          pend_v [2];
  int          pend_due [2];
  logic [31:0] pend_rd [2];
  logic        pend_err [2];
  logic [31:0] last_rd [2];
  logic        last_err [2];
  int          last_rsp_edge [2];
  int          nlow [2];
  bit          armed = 1'b0;
  int          n_checks = 0;
  int          n_errs = 0;
  int          m_loads, m_stores, m_errs;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL d%0d %s: got %h expected %h (edge %0d)", d, name, act, exp, cyc);
    end
  endtask

  // Byte-addressed view of the memory: loads gather bytes little-endian then extend.
  task automatic model_access(input int d, input bit w, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] x,
                              output logic [31:0] r, output logic er);
    int n;
    logic [31:0] val;
    n  = 1 << f[1:0];
    er = 1'b0;
    r  = 32'h0;
    if ((a >> 2) >= 32'(MS)) er = 1'b1;
    if (w && !(f inside {3'd0, 3'd1, 3'd2})) er = 1'b1;
    if (!w && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
    if (f[1:0] == 2'd1 && a[0]) er = 1'b1;
    if (f[1:0] == 2'd2 && a[1:0] != 2'd0) er = 1'b1;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[d][int'(a) + i] = x[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val[8*i +: 8] = mb[d][int'(a) + i];
        if (!f[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
        if (!f[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
        r = val;
      end
    end
    if (d == 0) begin
      if (er) m_errs++;
      else if (w) m_stores++;
      else m_loads++;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        logic expv;
        check("req_ready", d, 32'(rdy[d]), 32'(cyc >= busy[d]));
        if (rdy[d] === 1'b0) nlow[d]++;
        expv = 1'b0;
        if (pend_v[d] && pend_due[d] == cyc) begin
          expv        = 1'b1;
          pend_v[d]   = 1'b0;
          last_rd[d]  = pend_rd[d];
          last_err[d] = pend_err[d];
        end
        check("rsp_valid", d, 32'(rv[d]), 32'(expv));
        if (rv[d] === 1'b1) last_rsp_edge[d] = cyc;
        check("rsp_rdata", d, rd[d], last_rd[d]);
        check("rsp_err", d, 32'(re[d]), 32'(last_err[d]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v   = 2'b00;
    tick(1);
    for (int d = 0; d < 2; d++) begin
      pend_v[d]   = 1'b0;
      busy[d]     = cyc;
      last_rd[d]  = 32'h0;
      last_err[d] = 1'b0;
    end
    m_loads  = 0;
    m_stores = 0;
    m_errs   = 0;
    rst   = 1'b0;
    armed = 1'b1;
  endtask

  task automatic issue(input int d, input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] x, output logic [31:0] r, output logic er,
                       output int acc_edge);
    bit acc;
    acc = 1'b0;
    r = 32'h0;
    er = 1'b0;
    acc_edge = -1;
    v[d] = 1'b1; we[d] = w; f3[d] = f; ad[d] = a; wd[d] = x;
    for (int t = 0; t < 20 && !acc; t++) begin
      tick(1);
      if (cyc - 1 >= busy[d]) begin
        acc = 1'b1;
        acc_edge = cyc;
        model_access(d, w, f, a, x, r, er);
        pend_v[d]   = 1'b1;
        pend_due[d] = cyc + wc[d];
        pend_rd[d]  = r;
        pend_err[d] = er;
        busy[d]     = cyc + wc[d];
      end
    end
    if (!acc) begin
      n_checks++;
      n_errs++;
      $display("FAIL d%0d accept timeout", d);
    end
    v[d] = 1'b0;
    ad[d] = $urandom;
    wd[d] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic er;
    int k, k2;
    rst = 1'b0; v = 2'b00; we = 2'b00;
    for (int d = 0; d < 2; d++) begin
      f3[d] = 3'd0; ad[d] = 32'h0; wd[d] = 32'h0; nlow[d] = 0; last_rsp_edge[d] = -1;
    end
    tick(1);
    do_reset();
    check("reset req_ready", 0, 32'(rdy[0]), 32'h1);
    check("reset rsp_valid", 1, 32'(rv[1]), 32'h0);
    check("reset rsp_rdata", 0, rd[0], 32'h0);

    // Zero wait states: back-to-back byte loads.
    issue(0, 1, 3'd2, 32'h10, 32'h8081_7F02, r, er, k);
    nlow[0] = 0;
    issue(0, 0, 3'd0, 32'h10, 32'h0, r, er, k);  check("lit lb 0x10", 0, r, 32'h0000_0002);
    issue(0, 0, 3'd0, 32'h11, 32'h0, r, er, k2); check("lit lb 0x11", 0, r, 32'h0000_007F);
    check("lit b2b accept", 0, 32'(k2 - k), 32'd1);
    issue(0, 0, 3'd0, 32'h12, 32'h0, r, er, k);  check("lit lb 0x12", 0, r, 32'hFFFF_FF81);
    issue(0, 0, 3'd0, 32'h13, 32'h0, r, er, k);  check("lit lb 0x13", 0, r, 32'hFFFF_FF80);
    tick(2);
    check("lit ready never low", 0, 32'(nlow[0]), 32'd0);

    // Halfword store into a known word, then lw/lh/lhu.
    issue(0, 1, 3'd2, 32'h20, 32'h1111_1111, r, er, k);
    issue(0, 1, 3'd1, 32'h22, 32'h0000_BEEF, r, er, k);
    issue(0, 0, 3'd2, 32'h20, 32'h0, r, er, k); check("lit lw 0x20", 0, r, 32'hBEEF_1111);
    issue(0, 0, 3'd1, 32'h22, 32'h0, r, er, k); check("lit lh 0x22", 0, r, 32'hFFFF_BEEF);
    issue(0, 0, 3'd5, 32'h22, 32'h0, r, er, k); check("lit lhu 0x22", 0, r, 32'h0000_BEEF);

    // Faulting accesses.
    issue(0, 1, 3'd2, 32'h21, 32'hDEAD_BEEF, r, er, k); check("lit sw 0x21 err", 0, 32'(er), 32'h1);
    issue(0, 0, 3'd2, 32'h20, 32'h0, r, er, k); check("lit lw 0x20 unchanged", 0, r, 32'hBEEF_1111);
    issue(0, 0, 3'd1, 32'h23, 32'h0, r, er, k); check("lit lh 0x23 err", 0, 32'(er), 32'h1);
    issue(0, 0, 3'd2, 32'h100, 32'h0, r, er, k); check("lit lw 0x100 err", 0, 32'(er), 32'h1);
    issue(0, 0, 3'd2, 32'hFFFF_FFFC, 32'h0, r, er, k);
    issue(0, 0, 3'd3, 32'h10, 32'h0, r, er, k);
    issue(0, 1, 3'd4, 32'h10, 32'h0, r, er, k);
    issue(0, 1, 3'd2, 32'hFC, 32'hCAFE_F00D, r, er, k);
    issue(0, 0, 3'd2, 32'hFC, 32'h0, r, er, k); check("lit lw last word", 0, r, 32'hCAFE_F00D);
    tick(2);

    // Three wait states: latency and a held second request.
    issue(1, 1, 3'd2, 32'h40, 32'h1234_5678, r, er, k);
    issue(1, 0, 3'd2, 32'h40, 32'h0, r, er, k);
    check("lit w3 lw", 1, r, 32'h1234_5678);
    nlow[1] = 0;
    issue(1, 0, 3'd4, 32'h41, 32'h0, r, er, k2);
    check("lit w3 lbu", 1, r, 32'h0000_0056);
    check("lit w3 rsp latency", 1, 32'(last_rsp_edge[1] - k), 32'd3);
    check("lit w3 ready low cycles", 1, 32'(nlow[1]), 32'd3);
    check("lit w3 held accept", 1, 32'(k2 - k), 32'd4);
    tick(6);

    // Reset mid-operation: pending load dropped, stores stay committed.
    issue(1, 1, 3'd0, 32'h44, 32'h0000_00A5, r, er, k);
    tick(4);
    issue(1, 0, 3'd2, 32'h40, 32'h0, r, er, k);
    do_reset();
    check("lit post-reset ready", 1, 32'(rdy[1]), 32'h1);
    check("lit post-reset valid", 1, 32'(rv[1]), 32'h0);
    check("lit post-reset rdata", 1, rd[1], 32'h0);
    check("lit post-reset err", 1, 32'(re[1]), 32'h0);
    tick(5);
    check("lit dropped rsp", 1, 32'(last_rsp_edge[1] < k), 32'h1);
    issue(1, 1, 3'd0, 32'h45, 32'h0000_003C, r, er, k);
    do_reset();
    issue(1, 0, 3'd4, 32'h44, 32'h0, r, er, k); check("lit lbu 0x44", 1, r, 32'h0000_00A5);
    issue(1, 0, 3'd4, 32'h45, 32'h0, r, er, k); check("lit lbu 0x45", 1, r, 32'h0000_003C);
    tick(6);

`ifdef DMEM_PERF_EN
    do_reset();
    issue(0, 0, 3'd2, 32'h10, 32'h0, r, er, k);
    issue(0, 0, 3'd0, 32'h10, 32'h0, r, er, k);
    issue(0, 0, 3'd5, 32'h22, 32'h0, r, er, k);
    issue(0, 1, 3'd2, 32'h30, 32'h0102_0304, r, er, k);
    issue(0, 1, 3'd0, 32'h31, 32'h0000_0099, r, er, k);
    issue(0, 1, 3'd2, 32'h31, 32'h0000_0000, r, er, k);
    check("perf_loads", 0, 32'(pl), 32'(m_loads));
    check("perf_stores", 0, 32'(ps), 32'(m_stores));
    check("perf_errs", 0, 32'(pe), 32'(m_errs));
    check("lit perf_loads", 0, 32'(pl), 32'd3);
    check("lit perf_stores", 0, 32'(ps), 32'd2);
    check("lit perf_errs", 0, 32'(pe), 32'd1);
    do_reset();
    check("perf_loads cleared", 0, 32'(pl), 32'd0);
    check("perf_stores cleared", 0, 32'(ps), 32'd0);
    check("perf_errs cleared", 0, 32'(pe), 32'd0);
`endif

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
